ucode_sequencer: RTL and testbench

UCODE_SEQUENCER -- requirements
Module: ucode_sequencer

---
 rtl/ucode_sequencer.sv | 108 ++++++++++
 tb/tb_ucode_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/ucode_sequencer.sv
// ucode_sequencer: 16x8 microcode store stepping ALU opcodes onto instr/bus with read capture into result/flags.
// Optional UCODE_SEQ_SINGLE_STEP_EN adds a step input that gates each EXEC decode.
module ucode_sequencer #(
  parameter logic [3:0] HALT_OP = 4'hE
) (
  input  logic       clk,
  input  logic       grst,
`ifdef UCODE_SEQ_SINGLE_STEP_EN
  input  logic       step,
`endif
  input  logic       start,
  input  logic       prog_we,
  input  logic [3:0] prog_addr,
  input  logic [7:0] prog_data,
  output logic [3:0] instr,
  inout  wire  [3:0] bus,
  output logic       busy,
  output logic       done,
  output logic [3:0] result,
  output logic [3:0] flags
);
  typedef enum logic [1:0] {IDLE, EXEC, RD, DONE} state_t;
  state_t r_state, w_state;
  logic [7:0] r_mem [16];
  logic [3:0] r_pc, w_pc, r_instr, w_instr, r_imm, w_imm, r_result, w_result, r_flags, w_flags;
  logic       r_end, w_end, w_step, w_busy, w_rd;
  logic [7:0] w_word;
  logic [3:0] w_op;
`ifdef UCODE_SEQ_SINGLE_STEP_EN
  assign w_step = step;
`else
  assign w_step = 1'b1;
`endif
  assign w_busy = r_state == EXEC || r_state == RD;
  assign busy   = w_busy;
  assign done   = r_state == DONE;
  assign instr  = r_instr;
  assign result = r_result;
  assign flags  = r_flags;
  assign bus    = (r_instr == 4'd1 || r_instr == 4'd2 || r_instr == 4'd3) ? r_imm : 4'bz;
  assign w_word = r_mem[r_pc];
  assign w_op   = w_word[7:4];
  assign w_rd   = w_op == 4'd7 || w_op == 4'd8;
  // r_end marks that the word at pc=15 was issued, so the run ends instead of wrapping
  always_comb begin
    w_state  = r_state;
    w_pc     = r_pc;
    w_instr  = r_instr;
    w_imm    = r_imm;
    w_end    = r_end;
    w_result = r_result;
    w_flags  = r_flags;
    case (r_state)
      IDLE: begin
        w_instr = 4'd0;
        if (start) begin
          w_state = EXEC;
          w_pc    = 4'd0;
          w_end   = 1'b0;
        end
      end
      EXEC: begin
        if (!w_step) w_instr = 4'd0;
        else if (r_end || w_op == HALT_OP) begin
          w_instr = 4'd0;
          w_state = DONE;
        end else begin
          w_instr = w_op;
          w_imm   = w_word[3:0];
          w_state = w_rd ? RD : EXEC;
          w_end   = &r_pc;
          w_pc    = r_pc + {3'd0, ~&r_pc};
        end
      end
      RD: begin
        w_result = r_instr == 4'd7 ? bus : r_result;
        w_flags  = r_instr == 4'd8 ? bus : r_flags;
        w_state  = EXEC;
      end
      default: begin
        w_instr = 4'd0;
        w_state = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (grst) begin
      r_state  <= IDLE;
      r_pc     <= 4'd0;
      r_instr  <= 4'd0;
      r_imm    <= 4'd0;
      r_end    <= 1'b0;
      r_result <= 4'd0;
      r_flags  <= 4'd0;
    end else begin
      r_state  <= w_state;
      r_pc     <= w_pc;
      r_instr  <= w_instr;
      r_imm    <= w_imm;
      r_end    <= w_end;
      r_result <= w_result;
      r_flags  <= w_flags;
    end
  end
  always_ff @(posedge clk) begin
    if (!grst && prog_we && !w_busy) r_mem[prog_addr] <= prog_data;
  end
endmodule

// File: tb/tb_ucode_sequencer.sv
// tb_ucode_sequencer: random programs run against a trace-level model; a negedge monitor drains the expected queue.
module tb_ucode_sequencer;
  logic clk = 1'b0;
  logic grst, start, prog_we, busy, done;
  logic [3:0] prog_addr, instr, result, flags, resp;
  logic [7:0] prog_data;
  wire  [3:0] bus;
`ifdef UCODE_SEQ_SINGLE_STEP_EN
  logic step = 1'b1;
`endif
  assign bus = (instr inside {4'd1, 4'd2, 4'd3}) ? 4'bz : resp;
  ucode_sequencer dut (
    .clk(clk), .grst(grst),
`ifdef UCODE_SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .start(start), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .instr(instr), .bus(bus), .busy(busy), .done(done), .result(result), .flags(flags)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [3:0] instr;
    logic [3:0] bus;
    logic       done;
    logic [3:0] res;
    logic [3:0] flg;
  } exp_t;
  exp_t q[$];
  logic [7:0] m [16];
  logic [3:0] er, ef;
  int checks = 0, errors = 0;
  bit mon_en = 0;
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  function automatic exp_t mk(input logic [3:0] i, input logic [3:0] b, input logic d);
    exp_t x;
    x.instr = i; x.bus = b; x.done = d; x.res = er; x.flg = ef;
    return x;
  endfunction
  // Whole-run trace: one idle EXEC cycle, then each word until halt or the end of memory.
  task automatic build();
    bit halted = 0;
    q.push_back(mk(4'd0, resp, 1'b0));
    for (int pc = 0; pc < 16 && !halted; pc++) begin
      logic [3:0] op, imm;
      op = m[pc][7:4];
      imm = m[pc][3:0];
      if (op == 4'hE) halted = 1;
      else if (op == 4'd7 || op == 4'd8) begin
        if (op == 4'd7) er = resp; else ef = resp;
        q.push_back(mk(op, resp, 1'b0));
        q.push_back(mk(op, resp, 1'b0));
      end else q.push_back(mk(op, (op >= 4'd1 && op <= 4'd3) ? imm : resp, 1'b0));
    end
    q.push_back(mk(4'd0, resp, 1'b1));
  endtask
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      if (busy || done) begin
        if (q.size() == 0) chk("unexpected_output", {busy, done}, 0);
        else begin
          e = q.pop_front();
          chk("instr", instr, e.instr);
          chk("bus", bus, e.bus);
          chk("done", done, e.done);
          chk("busy", busy, !e.done);
          if (e.done) begin
            chk("result", result, e.res);
            chk("flags", flags, e.flg);
          end
        end
      end else chk("idle_instr", instr, 0);
    end
  end
  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    prog_we = 1; prog_addr = a; prog_data = d; m[a] = d;
    @(negedge clk);
    prog_we = 0;
  endtask
  task automatic run(input bit interfere, input bit wr_with_start);
    int n = 0;
    @(negedge clk);
    if (wr_with_start) begin
      prog_addr = 4'($urandom);
      prog_data = 8'($urandom);
      prog_we = 1;
      m[prog_addr] = prog_data;
    end
    resp = 4'($urandom_range(1, 15));
    build();
    start = 1;
    @(negedge clk);
    start = 0; prog_we = 0;
    while (q.size() != 0 && n < 80) begin
      if (interfere) begin
        start = busy && ($urandom_range(0, 2) == 0);
        prog_we = start;
        prog_addr = 4'($urandom);
        prog_data = 8'($urandom);
      end
      @(negedge clk);
      n++;
    end
    start = 0; prog_we = 0;
    if (q.size() != 0) begin
      chk("run_timeout", q.size(), 0);
      q.delete();
    end
    @(negedge clk);
  endtask
  initial begin
    logic [7:0] p37 [7];
    logic [7:0] prd [5];
    int n;
    p37 = '{8'h14, 8'h21, 8'h33, 8'h40, 8'h50, 8'h70, 8'hE0};
    prd = '{8'h12, 8'h70, 8'h80, 8'h3F, 8'hE0};
    grst = 1; start = 0; prog_we = 0; prog_addr = 0; prog_data = 0; resp = 0; er = 0; ef = 0;
    repeat (3) @(negedge clk);
    chk("rst_instr", instr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", flags, 0);
    grst = 0;
    for (int i = 0; i < 16; i++) wr(4'(i), i < 7 ? p37[i] : 8'hE0);
    mon_en = 1;
    run(0, 0);
    for (int i = 0; i < 16; i++) wr(4'(i), 8'h50);
    run(0, 0);
    for (int i = 0; i < 5; i++) wr(4'(i), prd[i]);
    run(1, 0);
    mon_en = 0;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    n = 0;
    while (instr != 4'd8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("reach_rd8", instr, 8);
    grst = 1;
    @(negedge clk);
    grst = 0;
    chk("midrd_instr", instr, 0);
    chk("midrd_busy", busy, 0);
    chk("midrd_done", done, 0);
    chk("midrd_flags", flags, 0);
    chk("midrd_result", result, 0);
    er = 0; ef = 0;
    @(negedge clk);
    mon_en = 1;
    run(0, 0);
    for (int r = 0; r < 30; r++) begin
      repeat ($urandom_range(0, 4)) wr(4'($urandom), 8'($urandom));
      run(1'($urandom), 1'($urandom));
    end
    mon_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
